// File: rtl/key_press_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_press_reader: synchronises and debounces one active-low DE2 KEY and    |
// | emits press/release/long-press pulses, a stable level and a press count.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_press_reader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 32
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_IN,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DB_PRESS   = 3'd1,
    S_HELD       = 3'd2,
    S_LONG_HELD  = 3'd3,
    S_DB_RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_k;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] w_db_cnt_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic             r_from_long;
  logic             w_from_long_nxt;

  logic             r_pressed;
  logic             r_press_pulse;
  logic             r_release_pulse;
  logic             r_long_pulse;
  logic [7:0]       r_press_count;
  logic             w_pressed_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_long_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Synchroniser presets to "released" so a key held through reset is
  // seen as a fresh edge once reset lifts.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= KEY_IN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_k = ~r_sync2;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state         <= S_IDLE;
      r_db_cnt        <= '0;
      r_hold_cnt      <= '0;
      r_from_long     <= 1'b0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      r_press_count   <= 8'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_db_cnt        <= w_db_cnt_nxt;
      r_hold_cnt      <= w_hold_cnt_nxt;
      r_from_long     <= w_from_long_nxt;
      r_pressed       <= w_pressed_nxt;
      r_press_pulse   <= w_press_nxt;
      r_release_pulse <= w_release_nxt;
      r_long_pulse    <= w_long_nxt;
      if (w_press_nxt) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_db_cnt_nxt    = r_db_cnt;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_from_long_nxt = r_from_long;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_db_cnt_nxt   = '0;
        w_hold_cnt_nxt = '0;
        if (w_k) begin
          w_state_nxt  = S_DB_PRESS;
          w_db_cnt_nxt = CNT_W'(1);
        end
      end
      S_DB_PRESS: begin
        if (!w_k) begin
          w_state_nxt  = S_IDLE;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == c_DB_LAST) begin
          w_state_nxt    = S_HELD;
          w_db_cnt_nxt   = '0;
          w_hold_cnt_nxt = '0;
          w_press_nxt    = 1'b1;
        end else begin
          w_db_cnt_nxt = sat_inc(r_db_cnt);
        end
      end
      S_HELD: begin
        if (!w_k) begin
          w_state_nxt     = S_DB_RELEASE;
          w_db_cnt_nxt    = CNT_W'(1);
          w_from_long_nxt = 1'b0;
        end else if (r_hold_cnt == c_LONG_LAST) begin
          w_state_nxt = S_LONG_HELD;
          w_long_nxt  = 1'b1;
        end else begin
          w_hold_cnt_nxt = sat_inc(r_hold_cnt);
        end
      end
      S_LONG_HELD: begin
        if (!w_k) begin
          w_state_nxt     = S_DB_RELEASE;
          w_db_cnt_nxt    = CNT_W'(1);
          w_from_long_nxt = 1'b1;
        end
      end
      S_DB_RELEASE: begin
        // Hold counter is left untouched so a bounce only pauses the hold timer.
        if (w_k) begin
          w_state_nxt  = r_from_long ? S_LONG_HELD : S_HELD;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == c_DB_LAST) begin
          w_state_nxt    = S_IDLE;
          w_db_cnt_nxt   = '0;
          w_hold_cnt_nxt = '0;
          w_release_nxt  = 1'b1;
        end else begin
          w_db_cnt_nxt = sat_inc(r_db_cnt);
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_db_cnt_nxt   = '0;
        w_hold_cnt_nxt = '0;
      end
    endcase

    w_pressed_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_LONG_HELD) ||
                    (w_state_nxt == S_DB_RELEASE);
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign long_pulse    = r_long_pulse;
  assign press_count   = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_key_press_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_press_reader: directed vector table plus hand sequences for the     |
// | debounced key reader (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_key_press_reader;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       KEY_IN;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  key_press_reader #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG),
    .CNT_W          (8)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .KEY_IN       (KEY_IN),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       rst_n;
    logic       key;
    int         n;
    logic       pressed;
    logic       pp;
    logic       rp;
    logic       lp;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   n_pp  = 0;
  int   n_rp  = 0;
  int   n_lp  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Step one clock and sample 1 ns after the rising edge, tallying pulses.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    if (press_pulse === 1'b1)   n_pp++;
    if (release_pulse === 1'b1) n_rp++;
    if (long_pulse === 1'b1)    n_lp++;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    KEY_IN  = 1'b1;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic wait_pp(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (press_pulse === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  function automatic logic [11:0] outs();
    return {pressed, press_pulse, release_pulse, long_pulse, press_count};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    int          all_held;
    logic [11:0] exp_o;

    // rst_n key  n  pressed pp rp lp cnt
    tbl.push_back('{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
    tbl.push_back('{1'b1, 1'b0,  4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    tbl.push_back('{1'b1, 1'b1,  5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    tbl.push_back('{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1});
    tbl.push_back('{1'b1, 1'b1,  3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1});
    tbl.push_back('{1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    // bouncy press: 2-cycle lows are rejected
    tbl.push_back('{1'b1, 1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
    // continue holding: long pulse 20 cycles after press pulse, only once
    tbl.push_back('{1'b1, 1'b0, 19, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    tbl.push_back('{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1});
    tbl.push_back('{1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    tbl.push_back('{1'b1, 1'b1,  5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    tbl.push_back('{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1});
    tbl.push_back('{1'b1, 1'b1,  3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1});

    RESET_N = 1'b0;
    KEY_IN  = 1'b1;
    #1;
    chk("reset_async_outs", 32'(outs()), 32'd0);
    tick();
    tick();
    chk("reset_outs", 32'(outs()), 32'd0);
    RESET_N = 1'b1;

    foreach (tbl[r]) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        RESET_N = tbl[r].rst_n;
        KEY_IN  = tbl[r].key;
        tick();
        exp_o = {tbl[r].pressed, tbl[r].pp, tbl[r].rp, tbl[r].lp, tbl[r].cnt};
        chk($sformatf("vec%0d_c%0d", r, c), 32'(outs()), 32'(exp_o));
      end
    end

    // Release glitch while HELD: no release, no extra press; long still fires once.
    do_reset();
    KEY_IN = 1'b0;
    wait_pp(30, cyc);
    chk("glitch_press_latency", 32'(cyc), 32'd6);
    n_pp = 0; n_rp = 0; n_lp = 0;
    all_held = 1;
    KEY_IN = 1'b1;
    tick();
    if (pressed !== 1'b1) all_held = 0;
    tick();
    if (pressed !== 1'b1) all_held = 0;
    KEY_IN = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pressed !== 1'b1) all_held = 0;
    end
    chk("glitch_pressed_held", 32'(all_held), 32'd1);
    chk("glitch_no_release", 32'(n_rp), 32'd0);
    chk("glitch_no_press", 32'(n_pp), 32'd0);
    repeat (30) tick();
    chk("glitch_long_once", 32'(n_lp), 32'd1);
    chk("glitch_count", 32'(press_count), 32'd1);
    KEY_IN = 1'b1;
    repeat (10) tick();

    // Reset asserted during DB_PRESS.
    do_reset();
    KEY_IN = 1'b0;
    repeat (4) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst_dbpress_outs", 32'(outs()), 32'd0);
    KEY_IN = 1'b1;
    tick();
    tick();
    RESET_N = 1'b1;
    n_pp = 0; n_rp = 0; n_lp = 0;
    repeat (12) tick();
    chk("rst_dbpress_no_pulses", 32'(n_pp + n_rp + n_lp), 32'd0);
    chk("rst_dbpress_count", 32'(press_count), 32'd0);

    // Reset asserted during HELD, key held through reset release.
    KEY_IN = 1'b0;
    wait_pp(30, cyc);
    chk("held_press_latency", 32'(cyc), 32'd6);
    repeat (3) tick();
    chk("held_before_rst", 32'({pressed, press_count}), 32'({1'b1, 8'd1}));
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst_held_async_outs", 32'(outs()), 32'd0);
    n_pp = 0; n_rp = 0; n_lp = 0;
    repeat (3) tick();
    chk("rst_held_during", 32'(outs()), 32'd0);
    RESET_N = 1'b1;
    wait_pp(30, cyc);
    chk("rst_release_press_latency", 32'(cyc), 32'd6);
    repeat (15) tick();
    chk("rst_release_one_press", 32'(n_pp), 32'd1);
    chk("rst_release_no_release", 32'(n_rp), 32'd0);
    chk("rst_release_state", 32'({pressed, press_count}), 32'({1'b1, 8'd1}));
    KEY_IN = 1'b1;
    repeat (10) tick();

    // Press counter wrap.
    do_reset();
    n_pp = 0;
    for (int p = 1; p <= 257; p++) begin
      KEY_IN = 1'b0;
      repeat (8) tick();
      KEY_IN = 1'b1;
      repeat (8) tick();
      if (p == 256) chk("wrap_256_count", 32'(press_count), 32'd0);
    end
    chk("wrap_257_count", 32'(press_count), 32'd1);
    chk("wrap_pulse_total", 32'(n_pp), 32'd257);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_press_reader.md
Name: key_press_reader

Overview:
- Input-side counterpart to the board LED drivers: reads one active-low DE2 push-button (KEY) clocked by CLOCK_50.
- Synchronises the raw key and debounces it.
- Emits single-cycle press, release and long-press events, plus a stable level and a wrapping press count.
- Feeds blink and mode logic that toggles LEDG outputs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must stay stable before a level change is accepted (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000, cycles held after accepted press before long_press fires (1 s at 50 MHz); must exceed DEBOUNCE_CYCLES.
- CNT_W, 32, width of internal duration counter; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge
- RESET_N  input  1  asynchronous active-low reset
- KEY_IN  input  1  raw button, active-low (0 = pressed), asynchronous to CLOCK_50
- pressed  output  1  debounced level, 1 while button is accepted as held
- press_pulse  output  1  one-cycle pulse on accepted press
- release_pulse  output  1  one-cycle pulse on accepted release
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_CYCLES
- press_count  output  8  number of accepted presses, wraps 255 -> 0

Behaviour:
Reset (RESET_N=0, asynchronous):
- State goes to IDLE; counter clears to 0.
- Synchroniser flops preset to 1 (released).
- All outputs go to 0.
- Reset asserted mid-press aborts without emitting any pulse.
- After release of reset, a key already held is accepted only after full debounce, so exactly one press_pulse occurs.

Synchroniser:
- Two flops on KEY_IN; k = inverted second flop (1 = pressed).
- Gives 2 cycles of latency before the FSM sees a change.

FSM states:
- IDLE: pressed=0, counter=0. On k=1 go to DB_PRESS with counter=1.
- DB_PRESS: if k=0, return to IDLE (glitch rejected, no pulse). Else increment. When counter reaches DEBOUNCE_CYCLES:
  - go to HELD, clear counter, set pressed=1;
  - press_pulse=1 for that one cycle;
  - press_count increments in the same cycle.
- HELD: if k=0, go to DB_RELEASE with counter=1. Else increment. When counter reaches LONG_CYCLES:
  - long_pulse=1 for one cycle;
  - go to LONG_HELD.
- LONG_HELD: counter frozen, no further long pulses. On k=0 go to DB_RELEASE with counter=1.
- DB_RELEASE: pressed stays 1. If k=1, return to the state it came from (HELD or LONG_HELD; needs one tracking bit). The HELD duration counter is not reset by a bounce, so the bounce time is lost and accepted. Else increment. When counter reaches DEBOUNCE_CYCLES:
  - go to IDLE, pressed=0;
  - release_pulse=1 for one cycle.

Timing and output rules:
- Latency from clean KEY_IN fall to press_pulse: 2 + DEBOUNCE_CYCLES cycles. Same for release.
- long_pulse occurs LONG_CYCLES cycles after press_pulse if the key is held steadily.
- Outputs are registered; no combinational path from KEY_IN.
- Pulses never overlap. press_pulse and release_pulse are separated by at least DEBOUNCE_CYCLES cycles.
- Counter saturates rather than wrapping in every state.
- press_count increments by exactly 1 per press_pulse; 255 -> 0 wraps silently.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20 for sim):
- Clean press held 10 cycles then release:
  - press_pulse exactly once, 6 cycles after KEY_IN fall;
  - pressed=1 until release_pulse, 6 cycles after KEY_IN rise;
  - press_count=1;
  - no long_pulse.
- Bouncy press: KEY_IN toggles 0/1 every 2 cycles for 12 cycles, then stays 0 -> exactly one press_pulse, 6 cycles after the final fall; press_count=1.
- Hold 40 cycles:
  - long_pulse exactly once, 20 cycles after press_pulse;
  - no second long_pulse;
  - release_pulse after release;
  - pulse order is press, long, release.
- Release glitch: while HELD, KEY_IN high for 2 cycles then low -> pressed stays 1, no release_pulse, no extra press_pulse.
- 256 clean presses -> press_count returns to 0; 257th press gives press_count=1.
- Reset mid-operation:
  - RESET_N low during DB_PRESS and again during HELD -> all outputs 0 immediately (asynchronous), no pulses;
  - key held through reset release -> one press_pulse 6 cycles after RESET_N rises.
